control_unit: RTL
=================

# control_unit

Multi-cycle control unit that sequences the 11-bit accumulator datapath (`datapath`) from a program memory. It fetches 16-bit instructions, holds them in an instruction register, decodes the 5-bit opcode into datapath strobes, and owns the program counter including conditional branches on the datapath's Z/N status flags. It sits between program memory (asynchronous read) and `datapath`/data memory; the top level wires its outputs directly to the datapath `*_in` ports.

## Interface

- DATA_WIDTH, 11, operand/immediate width (matches datapath)
- ADDR_WIDTH, 11, program address width
- OPCODE_WIDTH, 5, opcode field width; instruction width = OPCODE_WIDTH + DATA_WIDTH
- clock_in  input  1  single clock; all state changes on rising edge
- reset_n_in  input  1  reset, synchronous, active-low
- instruction_in  input  OPCODE_WIDTH+DATA_WIDTH  program memory read data; opcode in MSBs, operand in LSBs
- flag_Z_in / flag_N_in  input  1 each  datapath status flags
- program_address_out  output  ADDR_WIDTH  PC, drives program memory address
- operand_out  output  DATA_WIDTH  IR operand field to datapath `operand_in`
- op_alu_out  output  1  0 = add, 1 = subtract
- sel_A_out  output  2  accumulator source: 00 ALU, 01 operand, 10 data memory
- sel_B_out  output  1  ALU B source: 0 operand, 1 data memory
- acc_wr_out, status_wr_out, data_memory_wr_out  output  1 each  single-cycle write strobes
- acc_reset_out, status_reset_out  output  1 each  datapath register clears
- halted_out  output  1  high while in HALT

## Operation

- States: INIT, FETCH, EXECUTE, HALT. Outputs are combinational decodes of state + IR only.
- INIT: acc_reset_out = status_reset_out = 1, all write strobes 0; next FETCH.
- FETCH: IR <= instruction_in; strobes 0; next EXECUTE.
- EXECUTE: strobes asserted for this cycle only; PC updated at end of cycle; next FETCH (HALT for HLT).
- HALT: strobes 0, PC held, halted_out = 1; exit only via reset.
- Opcodes: 00000 HLT; 00001 STO (data_memory_wr); 00010 LD (sel_A=10, acc_wr); 00011 LDI (sel_A=01, acc_wr); 00100 ADD / 00101 ADDI (sel_A=00, sel_B=1/0, op_alu=0, acc_wr, status_wr); 00110 SUB / 00111 SUBI (same, op_alu=1); 01000 BEQ (Z); 01001 BNE (!Z); 01010 BGT (!Z & !N); 01011 BGE (!N); 01100 BLT (N); 01101 BLE (Z | N); 01110 JMP (always).
- Branch taken: PC <= operand[ADDR_WIDTH-1:0]; otherwise PC <= PC + 1. Flags sampled in EXECUTE of the branch.
- Undefined opcodes (01111–11111): NOP, PC + 1, no strobes.
- PC increment wraps 2^ADDR_WIDTH − 1 -> 0 silently.
- Don't-care selects (sel_A, sel_B, op_alu) drive 0 when unused.

## Timing

- Reset: reset_n_in low at a rising edge -> state INIT, PC = 0, IR = 0. While held low, state stays INIT (acc/status reset outputs continuously high, all write strobes 0, halted_out 0).
- Reset asserted during EXECUTE: the strobes of that cycle remain visible until the edge; the instruction's PC update is discarded.
- First fetch at address 0 occurs 2 edges after reset release (INIT, then FETCH).
- Every instruction takes exactly 2 cycles (FETCH + EXECUTE); no stalls.
- ALU instructions write flags at the same edge as the accumulator, so an immediately following branch sees them.
- program_address_out changes only at the edge ending EXECUTE; stable through FETCH.

## Structure

- Package `control_unit_pkg`: opcode enum (OPCODE_WIDTH bits), state enum, sel_A encodings (SEL_A_ALU, SEL_A_OPERAND, SEL_A_MEMORY), sel_B and op_alu constants. Shared with the top level and bench.
- One sub-module: `program_counter` (synchronous active-low reset to 0, load enable + load value, increment enable, wrap-around).
- FSM, IR and decode stay in `control_unit`.

## Test plan

- Reset: hold reset_n_in low 3 cycles -> acc_reset/status_reset high, PC = 0, strobes 0; release -> FETCH at address 0 two edges later.
- LDI 5; ADDI 3; STO 7 -> acc_wr in LDI EXECUTE with sel_A=01; ADDI has sel_A=00, sel_B=0, op_alu=0, status_wr; STO asserts only data_memory_wr with operand_out=7; PC 0→1→2→3.
- LDI 4; SUBI 4; BEQ 20 -> Z=1, PC = 20 after branch; repeat with SUBI 3 -> not taken, PC = 3.
- Branch matrix: for (Z,N) in {00, 01, 10}, each of BNE/BGT/BGE/BLT/BLE -> taken exactly per condition table.
- PC at 2047 with NOP (opcode 11111) -> PC = 0, no strobes; HLT -> halted_out = 1, PC frozen for 10 cycles.
- Reset pulse during ADD EXECUTE -> next state INIT, PC = 0, no PC increment applied.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: field widths, opcode and FSM state
// encodings, datapath select encodings and the branch-condition helper.
package control_unit_pkg;

  localparam int unsigned DATA_WIDTH   = 11;
  localparam int unsigned ADDR_WIDTH   = 11;
  localparam int unsigned OPCODE_WIDTH = 5;
  localparam int unsigned INSTR_WIDTH  = OPCODE_WIDTH + DATA_WIDTH;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OpHlt  = 5'b00000,
    OpSto  = 5'b00001,
    OpLd   = 5'b00010,
    OpLdi  = 5'b00011,
    OpAdd  = 5'b00100,
    OpAddi = 5'b00101,
    OpSub  = 5'b00110,
    OpSubi = 5'b00111,
    OpBeq  = 5'b01000,
    OpBne  = 5'b01001,
    OpBgt  = 5'b01010,
    OpBge  = 5'b01011,
    OpBlt  = 5'b01100,
    OpBle  = 5'b01101,
    OpJmp  = 5'b01110
  } opcode_e;

  typedef enum logic [1:0] {
    StInit,
    StFetch,
    StExecute,
    StHalt
  } state_e;

  // Accumulator source select
  localparam logic [1:0] SEL_A_ALU     = 2'b00;
  localparam logic [1:0] SEL_A_OPERAND = 2'b01;
  localparam logic [1:0] SEL_A_MEMORY  = 2'b10;

  // ALU B source select and ALU operation
  localparam logic SEL_B_OPERAND = 1'b0;
  localparam logic SEL_B_MEMORY  = 1'b1;
  localparam logic OP_ALU_ADD    = 1'b0;
  localparam logic OP_ALU_SUB    = 1'b1;

  // True when a branch/jump opcode should redirect the PC for the given flags.
  // Non-branch opcodes never redirect.
  function automatic logic branch_taken(logic [OPCODE_WIDTH-1:0] op, logic z, logic n);
    logic taken;
    taken = 1'b0;
    case (op)
      OpBeq:   taken = z;
      OpBne:   taken = ~z;
      OpBgt:   taken = ~z & ~n;
      OpBge:   taken = ~n;
      OpBlt:   taken = n;
      OpBle:   taken = z | n;
      OpJmp:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and program memory / datapath.
//   instruction_in          program memory read data (opcode in MSBs)
//   flag_Z_in, flag_N_in    datapath status flags
//   program_address_out     program counter
//   operand_out             IR operand field
//   op_alu_out, sel_A_out, sel_B_out  datapath selects
//   acc_wr_out, status_wr_out, data_memory_wr_out  write strobes
//   acc_reset_out, status_reset_out   datapath register clears
//   halted_out              high while halted
// master: control unit side; slave: memory/datapath (or bench) side.
interface control_unit_if;
  import control_unit_pkg::*;

  logic [INSTR_WIDTH-1:0] instruction_in;
  logic                   flag_Z_in;
  logic                   flag_N_in;
  logic [ADDR_WIDTH-1:0]  program_address_out;
  logic [DATA_WIDTH-1:0]  operand_out;
  logic                   op_alu_out;
  logic [1:0]             sel_A_out;
  logic                   sel_B_out;
  logic                   acc_wr_out;
  logic                   status_wr_out;
  logic                   data_memory_wr_out;
  logic                   acc_reset_out;
  logic                   status_reset_out;
  logic                   halted_out;

  modport master (
    input  instruction_in, flag_Z_in, flag_N_in,
    output program_address_out, operand_out, op_alu_out, sel_A_out, sel_B_out,
           acc_wr_out, status_wr_out, data_memory_wr_out, acc_reset_out,
           status_reset_out, halted_out
  );

  modport slave (
    output instruction_in, flag_Z_in, flag_N_in,
    input  program_address_out, operand_out, op_alu_out, sel_A_out, sel_B_out,
           acc_wr_out, status_wr_out, data_memory_wr_out, acc_reset_out,
           status_reset_out, halted_out
  );

endinterface

// File: rtl/control_unit_program_counter.sv
// Program counter: synchronous active-low clear to 0, load (priority) or
// increment with silent wrap at the top of the address space.
//   clock_in, reset_n_in  clock and synchronous active-low reset
//   load_en_in            load load_value_in at the edge
//   load_value_in         branch target
//   inc_en_in             increment at the edge (ignored when loading)
//   pc_out                current program counter
module control_unit_program_counter
  import control_unit_pkg::*;
(
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  load_en_in,
  input  logic [ADDR_WIDTH-1:0] load_value_in,
  input  logic                  inc_en_in,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  logic [ADDR_WIDTH-1:0] pc_q;

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      pc_q <= '0;
    end else if (load_en_in) begin
      pc_q <= load_value_in;
    end else if (inc_en_in) begin
      pc_q <= pc_q + ADDR_WIDTH'(1);
    end
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: INIT -> (FETCH -> EXECUTE)* -> HALT.
// FETCH latches the instruction into IR; EXECUTE decodes the IR opcode into
// single-cycle datapath strobes and updates the PC at the edge ending it.
//   clock_in    single clock, rising edge
//   reset_n_in  synchronous active-low reset
//   bus         control_unit_if master: instruction/flags in, PC/operand/strobes out
// Outputs are combinational decodes of state and IR only.
module control_unit
  import control_unit_pkg::*;
(
  input logic            clock_in,
  input logic            reset_n_in,
  control_unit_if.master bus
);

  state_e                  state_q;
  logic [INSTR_WIDTH-1:0]  ir_q;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0]   operand;
  logic                    in_execute;
  logic                    taken;
  logic                    pc_load;
  logic                    pc_inc;
  logic [ADDR_WIDTH-1:0]   pc;

  assign opcode  = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign operand = ir_q[DATA_WIDTH-1:0];

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q <= StInit;
      ir_q    <= '0;
    end else begin
      unique case (state_q)
        StInit:    state_q <= StFetch;
        StFetch: begin
          ir_q    <= bus.instruction_in;
          state_q <= StExecute;
        end
        StExecute: state_q <= (opcode == OpHlt) ? StHalt : StFetch;
        StHalt:    state_q <= StHalt;
      endcase
    end
  end

  // Flags are sampled during EXECUTE, so an ALU op writing them at the
  // previous EXECUTE edge is visible to an immediately following branch.
  assign in_execute = (state_q == StExecute);
  assign taken      = branch_taken(opcode, bus.flag_Z_in, bus.flag_N_in);
  assign pc_load    = in_execute & taken;
  assign pc_inc     = in_execute & ~taken & (opcode != OpHlt);

  control_unit_program_counter u_program_counter (
    .clock_in      (clock_in),
    .reset_n_in    (reset_n_in),
    .load_en_in    (pc_load),
    .load_value_in (operand[ADDR_WIDTH-1:0]),
    .inc_en_in     (pc_inc),
    .pc_out        (pc)
  );

  always_comb begin
    bus.acc_reset_out      = 1'b0;
    bus.status_reset_out   = 1'b0;
    bus.acc_wr_out         = 1'b0;
    bus.status_wr_out      = 1'b0;
    bus.data_memory_wr_out = 1'b0;
    bus.halted_out         = 1'b0;
    bus.sel_A_out          = SEL_A_ALU;
    bus.sel_B_out          = SEL_B_OPERAND;
    bus.op_alu_out         = OP_ALU_ADD;
    unique case (state_q)
      StInit: begin
        bus.acc_reset_out    = 1'b1;
        bus.status_reset_out = 1'b1;
      end
      StFetch: begin
      end
      StExecute: begin
        unique case (opcode)
          OpSto: bus.data_memory_wr_out = 1'b1;
          OpLd: begin
            bus.sel_A_out  = SEL_A_MEMORY;
            bus.acc_wr_out = 1'b1;
          end
          OpLdi: begin
            bus.sel_A_out  = SEL_A_OPERAND;
            bus.acc_wr_out = 1'b1;
          end
          OpAdd, OpAddi, OpSub, OpSubi: begin
            bus.acc_wr_out    = 1'b1;
            bus.status_wr_out = 1'b1;
            bus.sel_B_out     = (opcode == OpAdd || opcode == OpSub) ? SEL_B_MEMORY
                                                                     : SEL_B_OPERAND;
            bus.op_alu_out    = (opcode == OpSub || opcode == OpSubi) ? OP_ALU_SUB
                                                                      : OP_ALU_ADD;
          end
          // HLT, branches and undefined opcodes assert no strobes
          default: begin
          end
        endcase
      end
      StHalt: bus.halted_out = 1'b1;
    endcase
  end

  assign bus.program_address_out = pc;
  assign bus.operand_out         = operand;

endmodule
